// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus: req/addr/gnt toward memory,
// rvalid/rdata back, at most one transaction outstanding.
interface instr_fetch_if;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr_rdata
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_gnt,
        output instr_rvalid,
        output instr_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC generation, single-outstanding memory fetch, prefetch FIFO
// toward decode, redirect flush. Optional macro IF_BYPASS_EN adds an rvalid->decoder bypass.
module instr_fetch #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    instr_fetch_if.master        bus,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,
    output logic [31:0]          instr_o,
    output logic [31:0]          pc_o
);
    localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] BOOT_PC = BOOT_ADDR & ~32'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [31:0]      fifo_instr_q [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_after;
    logic             fifo_empty, push, pop, resp_in_wait;

    assign fifo_empty   = (count_q == '0);
    assign resp_in_wait = (state_q == S_WAIT) && bus.instr_rvalid;

`ifdef IF_BYPASS_EN
    logic bypass_valid, bypass_take;
    // A response landing in an empty FIFO goes straight to decode; it is
    // only buffered if decode does not take it this cycle.
    assign bypass_valid  = fifo_empty && resp_in_wait;
    assign bypass_take   = bypass_valid && !redirect_i && instr_ready_i;
    assign instr_valid_o = !redirect_i && (!fifo_empty || bypass_valid);
    assign instr_o       = bypass_valid ? bus.instr_rdata : fifo_instr_q[rd_ptr_q];
    assign pc_o          = bypass_valid ? req_pc_q : fifo_pc_q[rd_ptr_q];
    assign pop           = !redirect_i && !fifo_empty && instr_ready_i;
    assign push          = resp_in_wait && !redirect_i && !bypass_take;
`else
    assign instr_valid_o = !redirect_i && !fifo_empty;
    assign instr_o       = fifo_instr_q[rd_ptr_q];
    assign pc_o          = fifo_pc_q[rd_ptr_q];
    assign pop           = instr_valid_o && instr_ready_i;
    assign push          = resp_in_wait && !redirect_i;
`endif

    assign count_after     = count_q + CNT_W'(push) - CNT_W'(pop);
    assign bus.instr_req   = (state_q == S_REQ);
    assign bus.instr_addr  = fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            S_IDLE: if (count_q < DEPTH_C) state_d = S_REQ;
            S_REQ: begin
                if (bus.instr_gnt) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    req_pc_d   = fetch_pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: if (bus.instr_rvalid) state_d = (count_after < DEPTH_C) ? S_REQ : S_IDLE;
            S_DROP: if (bus.instr_rvalid) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
        // A redirect overrides the normal transition; the only question is
        // whether a granted-but-unanswered request must still be drained.
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~32'd3;
            case (state_q)
                S_REQ:   state_d = bus.instr_gnt ? S_DROP : S_REQ;
                S_WAIT:  state_d = bus.instr_rvalid ? S_REQ : S_DROP;
                S_DROP:  state_d = bus.instr_rvalid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= BOOT_PC;
            req_pc_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            if (redirect_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_after;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else if (push) begin
            fifo_instr_q[wr_ptr_q] <= bus.instr_rdata;
            fifo_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (BOOT_ADDR=0x100, FIFO_DEPTH=2) with a
// behavioural instruction memory whose word at address a is {16'hC0DE, a[15:0]}.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    always #5 clk = ~clk;

    instr_fetch_if bus_if ();

    instr_fetch #(.BOOT_ADDR(32'h100), .FIFO_DEPTH(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .bus           (bus_if),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } out_t;

    logic [31:0] req_log [$];
    logic [31:0] reqcyc_log [$];
    out_t        out_log [$];

    int n_compared   = 0;
    int n_mismatched = 0;

    int          gnt_delay = 0;
    int          rv_delay  = 0;
    int          gnt_cnt   = 0;
    int          rv_wait   = 0;
    bit          rv_pending = 1'b0;
    logic [31:0] rv_addr   = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: grant after gnt_delay extra req cycles, answer rv_delay+1 cycles after grant.
    initial begin
        bus_if.instr_gnt    = 1'b0;
        bus_if.instr_rvalid = 1'b0;
        bus_if.instr_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            bus_if.instr_gnt    = 1'b0;
            bus_if.instr_rvalid = 1'b0;
            if (rv_pending) begin
                if (rv_wait == 0) begin
                    bus_if.instr_rvalid = 1'b1;
                    bus_if.instr_rdata  = mem_word(rv_addr);
                    rv_pending = 1'b0;
                end else begin
                    rv_wait--;
                end
            end else if (bus_if.instr_req) begin
                if (gnt_cnt >= gnt_delay) begin
                    bus_if.instr_gnt = 1'b1;
                    rv_pending = 1'b1;
                    rv_wait    = rv_delay;
                    rv_addr    = bus_if.instr_addr;
                    gnt_cnt    = 0;
                end else begin
                    gnt_cnt++;
                end
            end else begin
                gnt_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (bus_if.instr_req) reqcyc_log.push_back(bus_if.instr_addr);
                if (bus_if.instr_req && bus_if.instr_gnt) begin
                    req_log.push_back(bus_if.instr_addr);
                    $display("request addr=%h", bus_if.instr_addr);
                end
                if (instr_valid_o && instr_ready_i) begin
                    out_log.push_back('{pc: pc_o, instr: instr_o});
                    $display("deliver pc=%h instr=%h", pc_o, instr_o);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rv_pending = 1'b0;
        gnt_cnt    = 0;
        req_log.delete();
        reqcyc_log.delete();
        out_log.delete();
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int budget, input string tag);
        int k = 0;
        while (out_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_value(tag, 32'(out_log.size() >= n), 32'd1);
    endtask

    task automatic wait_reqs(input int n, input int budget, input string tag);
        int k = 0;
        while (req_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_value(tag, 32'(req_log.size() >= n), 32'd1);
    endtask

    task automatic wait_gnt(input int budget, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(bus_if.instr_req && bus_if.instr_gnt) && k < budget);
        check_value(tag, 32'(bus_if.instr_req && bus_if.instr_gnt), 32'd1);
    endtask

    initial begin
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_req",   32'(bus_if.instr_req), 32'd0);
        check_value("rst_addr",  bus_if.instr_addr, 32'h100);
        check_value("rst_valid", 32'(instr_valid_o), 32'd0);
        check_value("rst_instr", instr_o, 32'h0);
        check_value("rst_pc",    pc_o, 32'h0);

        // Streaming with immediate memory and ready=1
        instr_ready_i = 1'b1;
        do_reset();
        wait_outs(3, 60, "t1_timeout");
        check_value("t1_req0", req_log[0], 32'h100);
        check_value("t1_req1", req_log[1], 32'h104);
        check_value("t1_req2", req_log[2], 32'h108);
        check_value("t1_pc0",  out_log[0].pc, 32'h100);
        check_value("t1_in0",  out_log[0].instr, 32'hC0DE0100);
        check_value("t1_pc1",  out_log[1].pc, 32'h104);
        check_value("t1_in1",  out_log[1].instr, 32'hC0DE0104);
        check_value("t1_pc2",  out_log[2].pc, 32'h108);
        check_value("t1_in2",  out_log[2].instr, 32'hC0DE0108);

        // FIFO full stalls requests
        instr_ready_i = 1'b0;
        do_reset();
        repeat (20) @(negedge clk);
        check_value("t2_nreq",  32'(req_log.size()), 32'd2);
        check_value("t2_req",   32'(bus_if.instr_req), 32'd0);
        check_value("t2_valid", 32'(instr_valid_o), 32'd1);
        check_value("t2_head",  pc_o, 32'h100);
        @(posedge clk); #1;
        instr_ready_i = 1'b1;
        wait_reqs(3, 40, "t2_timeout");
        check_value("t2_req2", req_log[2], 32'h108);
        check_value("t2_pc0",  out_log[0].pc, 32'h100);

        // Delayed grant holds the address stable
        instr_ready_i = 1'b0;
        gnt_delay     = 3;
        do_reset();
        repeat (30) @(negedge clk);
        check_value("t3_ncyc", 32'(reqcyc_log.size()), 32'd8);
        for (int i = 4; i < 8; i++) begin
            check_value($sformatf("t3_addr%0d", i), reqcyc_log[i], 32'h104);
        end
        check_value("t3_nreq", 32'(req_log.size()), 32'd2);
        gnt_delay = 0;

        // Redirect while waiting for the response
        instr_ready_i = 1'b1;
        rv_delay      = 2;
        do_reset();
        wait_gnt(20, "t4_gnt_timeout");
        @(posedge clk); #1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        @(negedge clk);
        check_value("t4_redir_valid", 32'(instr_valid_o), 32'd0);
        @(posedge clk); #1;
        redirect_i = 1'b0;
        wait_outs(1, 80, "t4_timeout");
        check_value("t4_req1", req_log[1], 32'h200);
        check_value("t4_pc0",  out_log[0].pc, 32'h200);
        check_value("t4_in0",  out_log[0].instr, 32'hC0DE0200);
        rv_delay = 0;

        // Redirect in the same cycle as the grant, unaligned target
        gnt_delay = 2;
        do_reset();
        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bus_if.instr_req && k < 20);
            check_value("t5_req_seen", 32'(bus_if.instr_req), 32'd1);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h203;
        @(negedge clk);
        check_value("t5_gnt_same", 32'(bus_if.instr_gnt), 32'd1);
        check_value("t5_valid",    32'(instr_valid_o), 32'd0);
        @(posedge clk); #1;
        redirect_i = 1'b0;
        @(negedge clk);
        check_value("t5_drop_req",   32'(bus_if.instr_req), 32'd0);
        check_value("t5_drop_valid", 32'(instr_valid_o), 32'd0);
        wait_outs(1, 80, "t5_timeout");
        check_value("t5_req1", req_log[1], 32'h200);
        check_value("t5_pc0",  out_log[0].pc, 32'h200);
        check_value("t5_in0",  out_log[0].instr, 32'hC0DE0200);
        gnt_delay = 0;

        // Reset during S_WAIT, stale response arrives the cycle after reset
        rv_delay = 1;
        do_reset();
        wait_gnt(20, "t6_gnt_timeout");
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(negedge clk);
        req_log.delete();
        reqcyc_log.delete();
        out_log.delete();
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_value("t6_stale_valid", 32'(instr_valid_o), 32'd0);
        check_value("t6_stale_req",   32'(bus_if.instr_req), 32'd0);
        @(negedge clk);
        check_value("t6_req",  32'(bus_if.instr_req), 32'd1);
        check_value("t6_addr", bus_if.instr_addr, 32'h100);
        @(negedge clk);
        check_value("t6_wait_valid", 32'(instr_valid_o), 32'd0);
        wait_outs(1, 40, "t6_timeout");
        check_value("t6_pc0", out_log[0].pc, 32'h100);
        check_value("t6_in0", out_log[0].instr, 32'hC0DE0100);
        rv_delay = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
